// File: rtl/simple_pkg.sv
// Shared definitions for the simple 16-bit pipeline: data widths, the NOP
// encoding and the address/instruction types used by PC, fetch and decode.
package simple_pkg;

  localparam int WIDTH = 16;

  typedef logic [WIDTH-1:0] addr_t;
  typedef logic [WIDTH-1:0] instr_t;

  localparam instr_t NOP = 16'h0000;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry capture/hold register for the instruction memory read data.
// Capture only fills an empty slot; clear wins over capture.
module fetch_skid_buffer #(
  parameter int WIDTH = simple_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             capture,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid    <= 1'b0;
      data_out <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (capture && !valid) begin
      valid    <= 1'b1;
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the synchronous instruction memory with pc,
// tracks the in-flight word, absorbs stalls with a skid slot and registers IF/ID.
module fetch_stage #(
  parameter int                              WIDTH = simple_pkg::WIDTH,
  parameter logic [simple_pkg::WIDTH-1:0]    NOP   = simple_pkg::NOP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] pcPlusOne,
  input  logic             branchFlag,
  input  logic             stall,
  output logic [WIDTH-1:0] imemAddr,
  input  logic [WIDTH-1:0] imemRdata,
  output logic             ce,
  output logic [WIDTH-1:0] ir,
  output logic [WIDTH-1:0] irPcPlusOne,
  output logic             irValid
);

  import simple_pkg::*;

  // Pending slot: describes the word currently presented on imemRdata.
  logic             pendValid;
  logic [WIDTH-1:0] pendPcPlusOne;

  logic             skidValid;
  logic [WIDTH-1:0] skidData;
  logic             skid_capture;
  logic             skid_clear;
  logic [WIDTH-1:0] next_word;

  assign imemAddr = pc;
  assign ce       = !stall;

  // The memory re-reads the held PC during a stall, so the in-flight word
  // must be captured on the first stalled edge or it is lost.
  assign skid_capture = stall && !branchFlag && pendValid;
  assign skid_clear   = branchFlag || !stall;
  assign next_word    = skidValid ? skidData : imemRdata;

  fetch_skid_buffer #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .capture (skid_capture),
    .clear   (skid_clear),
    .data_in (imemRdata),
    .data_out(skidData),
    .valid   (skidValid)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pendValid     <= 1'b0;
      pendPcPlusOne <= '0;
      ir            <= NOP;
      irPcPlusOne   <= '0;
      irValid       <= 1'b0;
    end else if (branchFlag) begin
      // irPcPlusOne deliberately holds across a flush.
      pendValid <= 1'b0;
      ir        <= NOP;
      irValid   <= 1'b0;
    end else if (!stall) begin
      ir            <= pendValid ? next_word : NOP;
      irValid       <= pendValid;
      irPcPlusOne   <= pendPcPlusOne;
      pendValid     <= 1'b1;
      pendPcPlusOne <= pcPlusOne;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a PC model and a synchronous memory
// model M[a] = a ^ 16'hA500.
module tb_fetch_stage;

  logic        clock;
  logic        reset;
  logic [15:0] pc;
  logic [15:0] pcPlusOne;
  logic        branchFlag;
  logic        stall;
  logic [15:0] imemAddr;
  logic [15:0] imemRdata;
  logic        ce;
  logic [15:0] ir;
  logic [15:0] irPcPlusOne;
  logic        irValid;
  logic [15:0] target;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  fetch_stage dut (
    .clock      (clock),
    .reset      (reset),
    .pc         (pc),
    .pcPlusOne  (pcPlusOne),
    .branchFlag (branchFlag),
    .stall      (stall),
    .imemAddr   (imemAddr),
    .imemRdata  (imemRdata),
    .ce         (ce),
    .ir         (ir),
    .irPcPlusOne(irPcPlusOne),
    .irValid    (irValid)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // PC block model: branch overrides ce.
  always @(posedge clock or negedge reset) begin
    if (!reset)          pc <= 16'h0000;
    else if (branchFlag) pc <= target;
    else if (ce)         pc <= pc + 16'h0001;
  end
  assign pcPlusOne = pc + 16'h0001;

  // Synchronous instruction memory: data valid the cycle after the address.
  always @(posedge clock) imemRdata <= imemAddr ^ 16'hA500;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    assert_cnt++;
    assert (observed === expected) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_ir(input string tag, input logic [15:0] exp_ir, input logic [15:0] exp_ppo,
                          input logic exp_valid);
    check({tag, "_ir"},    ir,          exp_ir);
    check({tag, "_ppo"},   irPcPlusOne, exp_ppo);
    check({tag, "_valid"}, {15'd0, irValid}, {15'd0, exp_valid});
  endtask

  initial begin
    reset      = 1'b0;
    stall      = 1'b0;
    branchFlag = 1'b0;
    target     = 16'h0000;

    // Reset state
    tick();
    tick();
    check_ir("rst", 16'h0000, 16'h0000, 1'b0);
    check("rst_addr", imemAddr, 16'h0000);
    check("rst_ce", {15'd0, ce}, 16'h0001);

    // Reset/stream
    reset = 1'b1;
    tick();
    check("first_edge_valid", {15'd0, irValid}, 16'h0000);
    tick();
    check_ir("stream0", 16'hA500, 16'h0001, 1'b1);
    tick();
    check_ir("stream1", 16'hA501, 16'h0002, 1'b1);
    tick();
    check_ir("stream2", 16'hA502, 16'h0003, 1'b1);
    tick();
    check_ir("stream3", 16'hA503, 16'h0004, 1'b1);
    check("stream_addr", imemAddr, 16'h0005);

    // Single stall
    stall = 1'b1;
    #1;
    check("stall1_ce", {15'd0, ce}, 16'h0000);
    tick();
    check_ir("stall1_hold", 16'hA503, 16'h0004, 1'b1);
    stall = 1'b0;
    tick();
    check_ir("stall1_rel0", 16'hA504, 16'h0005, 1'b1);
    tick();
    check_ir("stall1_rel1", 16'hA505, 16'h0006, 1'b1);
    check("long_pc", imemAddr, 16'h0007);

    // Long stall of 5 cycles at pc=7
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_ir("long_hold", 16'hA505, 16'h0006, 1'b1);
      check("long_addr", imemAddr, 16'h0007);
    end
    stall = 1'b0;
    tick();
    check_ir("long_rel0", 16'hA506, 16'h0007, 1'b1);
    tick();
    check_ir("long_rel1", 16'hA507, 16'h0008, 1'b1);

    // Branch to 0x0040
    branchFlag = 1'b1;
    target     = 16'h0040;
    tick();
    branchFlag = 1'b0;
    check_ir("br_n1", 16'h0000, 16'h0008, 1'b0);
    check("br_pc", imemAddr, 16'h0040);
    tick();
    check("br_n2_valid", {15'd0, irValid}, 16'h0000);
    check("br_n2_ir", ir, 16'h0000);
    tick();
    check_ir("br_n3", 16'hA540, 16'h0041, 1'b1);
    tick();
    check_ir("br_n4", 16'hA541, 16'h0042, 1'b1);

    // Branch during stall with skid full
    stall = 1'b1;
    tick();
    check_ir("bs_fill", 16'hA541, 16'h0042, 1'b1);
    branchFlag = 1'b1;
    target     = 16'h0080;
    tick();
    branchFlag = 1'b0;
    stall      = 1'b0;
    check("bs_n1_valid", {15'd0, irValid}, 16'h0000);
    check("bs_n1_ir", ir, 16'h0000);
    tick();
    check("bs_n2_valid", {15'd0, irValid}, 16'h0000);
    check("bs_n2_ir", ir, 16'h0000);
    tick();
    check_ir("bs_n3", 16'hA580, 16'h0081, 1'b1);
    tick();
    check_ir("bs_n4", 16'hA581, 16'h0082, 1'b1);

    // Async reset between edges
    #2;
    reset = 1'b0;
    stall = 1'b1;
    #1;
    check_ir("async_rst", 16'h0000, 16'h0000, 1'b0);
    check("async_ce", {15'd0, ce}, 16'h0000);
    check("async_addr", imemAddr, 16'h0000);
    stall = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("rerel_edge1_valid", {15'd0, irValid}, 16'h0000);
    tick();
    check_ir("rerel_stream0", 16'hA500, 16'h0001, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
